rgb_pwm_decoder: RTL and testbench

Receive-side counterpart of the RGB PWM controller: measures the duty cycle of three incoming PWM lines (red, green, blue) and recovers the 8-bit colour intensities that produced them. Each channel is synchronised, frame-aligned on its rising edge, and measured over one full period. The channel handles constant-level (0 % / 100 %) inputs via timeout. Results are also repacked into RGB565 so the board's switch-word format can be read back and compared in loopback tests.

---
 rtl/rgb_pwm_decoder_pkg.sv | 24 ++
 rtl/rgb_pwm_decoder_pwm_capture.sv | 98 +++++++++
 rtl/rgb_pwm_decoder.sv | 76 +++++++
 tb/tb_rgb_pwm_decoder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pwm_decoder_pkg.sv
// rtl/rgb_pwm_decoder_pkg.sv - shared channel state, 565 field widths and duty scaling for rgb_pwm_decoder
package rgb_pwm_decoder_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    MEAS  = 2'd1,
    STUCK = 2'd2
  } chan_state_t;

  localparam int PERIOD_DEF  = 256;
  localparam int PER_TOL_DEF = 2;
  localparam int TIMEOUT_DEF = 1024;

  localparam int DUTY_W = 8;
  localparam int R565_W = 5;
  localparam int G565_W = 6;
  localparam int B565_W = 5;

  // right shift that maps a high-cycle count within one PERIOD frame onto 0..255
  function automatic int duty_shift(input int period);
    return $clog2(period) - DUTY_W;
  endfunction

endpackage

// File: rtl/rgb_pwm_decoder_pwm_capture.sv
// rtl/rgb_pwm_decoder_pwm_capture.sv - one PWM channel: synchroniser, frame counters, FSM, duty latch
module rgb_pwm_decoder_pwm_capture
  import rgb_pwm_decoder_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int PER_TOL = PER_TOL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              upd,
  output logic              err
);

  localparam int CW    = $clog2(TIMEOUT + 1);
  localparam int SHIFT = duty_shift(PERIOD);

  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] PER_LO   = CW'(PERIOD - PER_TOL);
  localparam logic [CW-1:0] PER_HI   = CW'(PERIOD + PER_TOL);
  localparam logic [CW-1:0] DUTY_MAX = CW'(255);

  logic              meta;
  logic              lvl;
  logic              lvl_d;
  logic              rise;
  logic              per_ok;
  chan_state_t       state;
  logic [CW-1:0]     per_cnt;
  logic [CW-1:0]     hi_cnt;
  logic [CW-1:0]     hi_scaled;
  logic [DUTY_W-1:0] duty_meas;

  // two-flop synchroniser plus one delayed copy for rising-edge detection
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      meta  <= 1'b0;
      lvl   <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      meta  <= pwm;
      lvl   <= meta;
      lvl_d <= lvl;
    end
  end

  assign rise      = lvl & ~lvl_d;
  assign per_ok    = (per_cnt >= PER_LO) && (per_cnt <= PER_HI);
  assign hi_scaled = hi_cnt >> SHIFT;
  assign duty_meas = (hi_scaled > DUTY_MAX) ? 8'hFF : hi_scaled[DUTY_W-1:0];

  // channel FSM; the rising-edge cycle is counted as cycle 1 of the new frame,
  // so per_cnt equals the frame length when the next rise arrives
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= SYNC;
      per_cnt <= '0;
      hi_cnt  <= '0;
      duty    <= '0;
      upd     <= 1'b0;
      err     <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (rise) begin
        state   <= MEAS;
        per_cnt <= ONE;
        hi_cnt  <= ONE;
        if (state == MEAS) begin
          if (per_ok) begin
            duty <= duty_meas;
            err  <= 1'b0;
            upd  <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (per_cnt == CNT_MAX) begin
        // no edge for TIMEOUT cycles: line is static, report 0 or 255 and
        // restart the count so the value is re-asserted every TIMEOUT cycles
        state   <= STUCK;
        per_cnt <= ONE;
        hi_cnt  <= '0;
        duty    <= lvl ? 8'hFF : 8'h00;
        err     <= 1'b0;
        upd     <= 1'b1;
      end else begin
        per_cnt <= per_cnt + ONE;
        if (lvl) begin
          hi_cnt <= hi_cnt + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_decoder.sv
// rtl/rgb_pwm_decoder.sv - three-channel PWM duty decoder with RGB565 repack (RGB_DECODE_ROUND_EN selects rounding)
module rgb_pwm_decoder
  import rgb_pwm_decoder_pkg::*;
#(
  parameter int PERIOD  = PERIOD_DEF,
  parameter int PER_TOL = PER_TOL_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        r_in,
  input  logic        g_in,
  input  logic        b_in,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [15:0] rgb565_out,
  output logic        valid_out,
  output logic [2:0]  err_out
);

  logic [DUTY_W-1:0] r_val;
  logic [DUTY_W-1:0] g_val;
  logic [DUTY_W-1:0] b_val;
  logic [2:0]        upd;
  logic [2:0]        err;
  logic [R565_W-1:0] r_fld;
  logic [G565_W-1:0] g_fld;
  logic [B565_W-1:0] b_fld;

  rgb_pwm_decoder_pwm_capture #(.PERIOD(PERIOD), .PER_TOL(PER_TOL), .TIMEOUT(TIMEOUT)) u_cap_r (
    .clk_in(clk_in), .rst_in(rst_in), .pwm(r_in), .duty(r_val), .upd(upd[0]), .err(err[0])
  );

  rgb_pwm_decoder_pwm_capture #(.PERIOD(PERIOD), .PER_TOL(PER_TOL), .TIMEOUT(TIMEOUT)) u_cap_g (
    .clk_in(clk_in), .rst_in(rst_in), .pwm(g_in), .duty(g_val), .upd(upd[1]), .err(err[1])
  );

  rgb_pwm_decoder_pwm_capture #(.PERIOD(PERIOD), .PER_TOL(PER_TOL), .TIMEOUT(TIMEOUT)) u_cap_b (
    .clk_in(clk_in), .rst_in(rst_in), .pwm(b_in), .duty(b_val), .upd(upd[2]), .err(err[2])
  );

`ifdef RGB_DECODE_ROUND_EN
  // (v + half) >> n is the truncated field plus the first dropped bit;
  // it overflows only when every kept bit and that dropped bit are set
  assign r_fld = (&r_val[7:2]) ? 5'h1F : (r_val[7:3] + 5'(r_val[2]));
  assign g_fld = (&g_val[7:1]) ? 6'h3F : (g_val[7:2] + 6'(g_val[1]));
  assign b_fld = (&b_val[7:2]) ? 5'h1F : (b_val[7:3] + 5'(b_val[2]));
`else
  assign r_fld = r_val[7:3];
  assign g_fld = g_val[7:2];
  assign b_fld = b_val[7:3];
`endif

  // register all channel values and the 565 word together whenever any channel updates
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_out      <= '0;
      g_out      <= '0;
      b_out      <= '0;
      rgb565_out <= '0;
      valid_out  <= 1'b0;
      err_out    <= '0;
    end else begin
      valid_out <= |upd;
      err_out   <= err;
      if (|upd) begin
        r_out      <= r_val;
        g_out      <= g_val;
        b_out      <= b_val;
        rgb565_out <= {r_fld, g_fld, b_fld};
      end
    end
  end

endmodule

// File: tb/tb_rgb_pwm_decoder.sv
// tb/tb_rgb_pwm_decoder.sv - directed table-driven bench for rgb_pwm_decoder
module tb_rgb_pwm_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        r_in = 1'b0;
  logic        g_in = 1'b0;
  logic        b_in = 1'b0;
  logic [7:0]  r_out;
  logic [7:0]  g_out;
  logic [7:0]  b_out;
  logic [15:0] rgb565_out;
  logic        valid_out;
  logic [2:0]  err_out;

  rgb_pwm_decoder dut (
    .clk_in(clk_in), .rst_in(rst_in), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .rgb565_out(rgb565_out),
    .valid_out(valid_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;
  int vcount   = 0;

  always @(negedge clk_in) begin
    if (valid_out) vcount++;
  end

  typedef struct {
    int          per;
    int          hr;
    int          hg;
    int          hb;
    logic [7:0]  er;
    logic [7:0]  eg;
    logic [7:0]  eb;
    logic [15:0] e565_t;
    logic [15:0] e565_r;
    logic [2:0]  eerr;
    int          env;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input int per, input int hr, input int hg, input int hb,
                              input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                              input logic [15:0] e565_t, input logic [15:0] e565_r,
                              input logic [2:0] eerr, input int env);
    vec_t v;
    v.per = per; v.hr = hr; v.hg = hg; v.hb = hb;
    v.er = er; v.eg = eg; v.eb = eb;
    v.e565_t = e565_t; v.e565_r = e565_r; v.eerr = eerr; v.env = env;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic g, input logic b);
    @(negedge clk_in);
    r_in = r;
    g_in = g;
    b_in = b;
  endtask

  task automatic drive_frames(input int nf, input int per, input int hr, input int hg, input int hb);
    for (int f = 0; f < nf; f++) begin
      for (int c = 0; c < per; c++) step(c < hr, c < hg, c < hb);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
  endtask

  initial begin
    int snap;
    int first;
    logic [15:0] exp565;

    vecs[0] = mk(256, 128,  64,  32, 8'h80, 8'h40, 8'h20, 16'h8204, 16'h8204, 3'b000, 2);
    vecs[1] = mk(256, 248, 252, 248, 8'hF8, 8'hFC, 8'hF8, 16'hFFFF, 16'hFFFF, 3'b000, 2);
    vecs[2] = mk(256, 255, 255, 255, 8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'hFFFF, 3'b000, 2);
    vecs[3] = mk(258,   7,   3,  28, 8'h07, 8'h03, 8'h1C, 16'h0003, 16'h0824, 3'b000, 2);
    vecs[4] = mk(254,   1, 165,  90, 8'h01, 8'hA5, 8'h5A, 16'h052B, 16'h052B, 3'b000, 2);
    vecs[5] = mk(300, 150, 150, 150, 8'h01, 8'hA5, 8'h5A, 16'h052B, 16'h052B, 3'b111, 0);
    vecs[6] = mk(259,  16,  16,  16, 8'h01, 8'hA5, 8'h5A, 16'h052B, 16'h052B, 3'b111, 0);
    vecs[7] = mk(253,  16,  16,  16, 8'h01, 8'hA5, 8'h5A, 16'h052B, 16'h052B, 3'b111, 0);
    vecs[8] = mk(256,  48,  48,  48, 8'h30, 8'h30, 8'h30, 16'h3186, 16'h3186, 3'b000, 2);

    // reset values
    repeat (2) @(negedge clk_in);
    check("rst_r", r_out, 0);
    check("rst_g", g_out, 0);
    check("rst_b", b_out, 0);
    check("rst_565", rgb565_out, 0);
    check("rst_valid", valid_out, 0);
    check("rst_err", err_out, 0);

    // latency of the first update: second rise, pulse three cycles after the pin edge
    do_reset();
    snap = vcount;
    drive_frames(1, 256, 128, 0, 0);
    check("lat_no_update_first_rise", vcount - snap, 0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0, 1'b0);
      check($sformatf("lat_valid_early%0d", k), valid_out, 0);
    end
    step(1'b1, 1'b0, 1'b0);
    check("lat_valid", valid_out, 1);
    check("lat_r", r_out, 8'h80);
    check("lat_565_r", rgb565_out[15:11], 5'h10);
    step(1'b1, 1'b0, 1'b0);
    check("lat_valid_one_cycle", valid_out, 0);

    // static lines: g/r low and b high from reset
    do_reset();
    b_in = 1'b1;
    first = 0;
    for (int p = 1; p <= 2050; p++) begin
      step(1'b0, 1'b0, 1'b1);
      if (first == 0 && valid_out) first = p;
      if (p == 1100) begin
        check("stuck_r", r_out, 8'h00);
        check("stuck_g", g_out, 8'h00);
        check("stuck_b", b_out, 8'hFF);
        check("stuck_err", err_out, 0);
        check("stuck_565", rgb565_out, 16'h001F);
      end
      if (p == 2049) check("stuck_repeat_quiet", valid_out, 0);
      if (p == 2050) check("stuck_repeat_valid", valid_out, 1);
    end
    check("stuck_first_valid_cycle", first, 1026);

    // table of frame patterns, each applied for three frames
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive_frames(1, vecs[i].per, vecs[i].hr, vecs[i].hg, vecs[i].hb);
      snap = vcount;
      drive_frames(2, vecs[i].per, vecs[i].hr, vecs[i].hg, vecs[i].hb);
`ifdef RGB_DECODE_ROUND_EN
      exp565 = vecs[i].e565_r;
`else
      exp565 = vecs[i].e565_t;
`endif
      check($sformatf("v%0d_r", i), r_out, vecs[i].er);
      check($sformatf("v%0d_g", i), g_out, vecs[i].eg);
      check($sformatf("v%0d_b", i), b_out, vecs[i].eb);
      check($sformatf("v%0d_565", i), rgb565_out, exp565);
      check($sformatf("v%0d_err", i), err_out, vecs[i].eerr);
      check($sformatf("v%0d_nvalid", i), vcount - snap, vecs[i].env);
    end

    // asynchronous reset in the middle of a frame
    drive_frames(3, 256, 64, 64, 64);
    check("mid_pre_r", r_out, 8'h40);
    for (int c = 0; c < 20; c++) step(1'b1, 1'b1, 1'b1);
    #2;
    rst_in = 1'b0;
    r_in = 1'b0; g_in = 1'b0; b_in = 1'b0;
    #1;
    check("mid_async_r", r_out, 0);
    check("mid_async_565", rgb565_out, 0);
    check("mid_async_valid", valid_out, 0);
    check("mid_async_err", err_out, 0);
    repeat (2) @(negedge clk_in);
    rst_in = 1'b1;
    snap = vcount;
    drive_frames(1, 256, 64, 64, 64);
    check("mid_after_one_rise_r", r_out, 0);
    check("mid_after_one_rise_nvalid", vcount - snap, 0);
    drive_frames(1, 256, 64, 64, 64);
    check("mid_after_two_rises_r", r_out, 8'h40);
    check("mid_after_two_rises_nvalid", vcount - snap, 1);

    // constant high, then PWM at 0x20
    do_reset();
    r_in = 1'b1; g_in = 1'b1; b_in = 1'b1;
    for (int p = 0; p < 1100; p++) step(1'b1, 1'b1, 1'b1);
    check("hi_stuck_565", rgb565_out, 16'hFFFF);
    check("hi_stuck_r", r_out, 8'hFF);
    snap = vcount;
    drive_frames(2, 256, 32, 32, 32);
    check("hi_first_rise_r", r_out, 8'hFF);
    check("hi_first_rise_nvalid", vcount - snap, 0);
    drive_frames(1, 256, 32, 32, 32);
    check("hi_second_rise_r", r_out, 8'h20);
    check("hi_second_rise_g", g_out, 8'h20);
    check("hi_second_rise_565", rgb565_out, 16'h2104);
    check("hi_second_rise_nvalid", vcount - snap, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
